psum_post: RTL
==============

Name: psum_post

Overview:
- Post-processing stage directly downstream of the conv partial-sum buffer.
- Consumes each finished 25-bit accumulated sum when the buffer flags it valid, then:
  - adds a per-channel bias,
  - applies a rounding arithmetic right shift,
  - applies optional ReLU,
  - saturates to signed 8-bit.
- Packs four results per 32-bit word into a small output FIFO, which the output feature-map writer drains via valid/ready.
- Upstream has no backpressure, so this block accepts one input every cycle.

Parameters:
- DATA_WIDTH, 25, input partial-sum width (signed).
- OUT_WIDTH, 8, quantized result width (signed).
- PACK, 4, results per output word.
- SHIFT_WIDTH, 5, width of the requantization shift amount.
- OFIFO_DEPTH, 4, output word FIFO depth (power of two).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_bias  in  DATA_WIDTH  signed bias; sampled with each input beat.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount, 0..DATA_WIDTH-1.
- cfg_relu_en  in  1  1 = clamp negative results to 0.
- psum_valid  in  1  input beat valid; driven by the buffer's fifo-out-valid.
- psum_data  in  DATA_WIDTH  signed partial sum.
- psum_last  in  1  with psum_valid: last element of the row; flushes a partial word.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  PACK*OUT_WIDTH  packed results; element 0 in the LSBs.
- out_keep  out  PACK  per-byte valid mask.
- overflow_err  out  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all pipeline valids, pack count, FIFO pointers and overflow_err go to 0;
  - out_valid=0, out_data=0, out_keep=0.
  - Reset mid-row discards any partial word.
- S1 (registered): sum1 = sign-extended psum_data + cfg_bias, computed at DATA_WIDTH+1 bits with no wrap.
- S2 (registered):
  - r = (sum1 + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift, arithmetic, round-half-up;
  - if cfg_relu_en and r<0, then r=0;
  - saturate to [-128, 127].
- S3 pack:
  - Each valid S2 result writes lane pack_cnt; pack_cnt then increments.
  - Word push occurs when pack_cnt==PACK-1, or when the beat carries last.
  - On push: keep = lanes written, unwritten lanes = 0, pack_cnt resets to 0.
  - psum_last travels alongside the data through S1/S2.
- Latency: a full word is visible on out_valid 3 cycles after its 4th input beat (FIFO empty, fall-through output).
- FIFO handshake:
  - Word transfers when out_valid && out_ready.
  - out_data/out_keep hold stable while out_valid && !out_ready.
  - Push into a full FIFO in the same cycle as a pop is allowed.
  - Push into a full FIFO with no pop drops the word and sets overflow_err; it clears only on rst.
  - Empty FIFO: out_valid=0.
- Pointer arithmetic wraps modulo OFIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- Config ports are assumed static within a row; changing them mid-row affects only subsequent beats.

Optional Feature:
- Macro: PSUM_POST_SAT_CNT_EN.
- When defined:
  - adds output sat_cnt (16 bits), counting S2 results clipped by saturation (ReLU zeroing is not counted);
  - the counter saturates at 0xFFFF and clears on rst.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the requant result type (signed OUT_WIDTH),
  - saturation bounds OUT_MAX=127 and OUT_MIN=-128,
  - a rounding-shift function usable by other post stages.
- One natural sub-module: psum_post_ofifo, the word FIFO with keep sideband and overflow flag.

Test Plan:
- shift=0, bias=0, relu=0; inputs 1,2,3,4 -> one word 0x04030201, keep=4'hF, out_valid 3 cycles after beat 4.
- bias=10, shift=2; input 5 -> (15+2)>>2 = 4 -> lane value 0x04.
- relu=1, input -300 -> 0; relu=0, input -300 -> -128 (0x80); input 1000 -> 127 (0x7F).
- 3 beats then psum_last on the 3rd -> word with keep=4'h7, lane 3 = 0; next row starts at lane 0.
- out_ready=0 while 5 full words arrive:
  - first 4 are stored, the 5th is dropped, overflow_err=1;
  - raise out_ready -> 4 words drain in order and data is held stable while stalled.
- Assert rst after 2 beats of a row -> out_valid=0; next 4 beats form a clean word from lane 0.

Source files
------------

// File: rtl/psum_post_pkg.sv
// rtl/psum_post_pkg.sv - shared requantization types, bounds and rounding-shift helper
package psum_post_pkg;

  localparam int OUT_W    = 8;
  localparam int RS_WIDTH = 32;
  localparam int OUT_MAX  = 127;
  localparam int OUT_MIN  = -128;

  typedef logic signed [OUT_W-1:0] requant_t;

  // Arithmetic right shift with round-half-up; a zero shift passes the value through.
  function automatic logic signed [RS_WIDTH-1:0] round_shift(
    input logic signed [RS_WIDTH-1:0] v,
    input logic        [4:0]          sh
  );
    logic signed [RS_WIDTH-1:0] half;
    logic signed [RS_WIDTH-1:0] biased;
    half = '0;
    if (sh != 5'd0) half[sh - 5'd1] = 1'b1;
    biased = v + half;
    round_shift = biased >>> sh;
  endfunction

endpackage

// File: rtl/psum_post_ofifo.sv
// rtl/psum_post_ofifo.sv - output word FIFO with keep sideband and sticky overflow flag
module psum_post_ofifo #(
  parameter int WIDTH  = 32,
  parameter int KEEP_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic [KEEP_W-1:0] push_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              overflow_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH+KEEP_W-1:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    wr_en;
  logic [WIDTH+KEEP_W-1:0] rd_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && out_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : rd_entry[WIDTH+KEEP_W-1:KEEP_W];
  assign out_keep  = empty ? '0 : rd_entry[KEEP_W-1:0];

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr[AW-1:0]] <= {push_data, push_keep};
  end

  // Pointer advance and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: rtl/psum_post.sv
// rtl/psum_post.sv - bias/round-shift/ReLU/saturate and pack partial sums; PSUM_POST_SAT_CNT_EN adds sat_cnt
module psum_post
  import psum_post_pkg::*;
#(
  parameter int DATA_WIDTH  = 25,
  parameter int OUT_WIDTH   = 8,
  parameter int PACK        = 4,
  parameter int SHIFT_WIDTH = 5,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  cfg_bias,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          cfg_relu_en,
  input  logic                          psum_valid,
  input  logic signed [DATA_WIDTH-1:0]  psum_data,
  input  logic                          psum_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PACK*OUT_WIDTH-1:0]     out_data,
  output logic [PACK-1:0]               out_keep,
`ifdef PSUM_POST_SAT_CNT_EN
  output logic [15:0]                   sat_cnt,
`endif
  output logic                          overflow_err
);

  localparam int CNT_W  = $clog2(PACK);
  localparam int WORD_W = PACK * OUT_WIDTH;

  // S1 state
  logic                         s1_valid;
  logic                         s1_last;
  logic                         s1_relu;
  logic [SHIFT_WIDTH-1:0]       s1_shift;
  logic signed [DATA_WIDTH:0]   s1_sum;

  // S2 combinational requantization
  logic signed [RS_WIDTH-1:0]   s2_ext;
  logic signed [RS_WIDTH-1:0]   s2_rnd;
  logic signed [RS_WIDTH-1:0]   s2_rect;
  logic                         s2_clip_hi;
  logic                         s2_clip_lo;
  requant_t                     s2_sat;

  // S2 state
  logic                         s2_valid;
  logic                         s2_last;
  requant_t                     s2_res;

  // Pack state
  logic [CNT_W-1:0]             pack_cnt;
  logic [WORD_W-1:0]            pack_data;
  logic [WORD_W-1:0]            word;
  logic [PACK-1:0]              word_keep;
  logic                         word_push;

  // Bias add at one extra bit so the sum cannot wrap; config travels with the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_shift <= '0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= psum_valid;
      s1_last  <= psum_valid && psum_last;
      s1_relu  <= cfg_relu_en;
      s1_shift <= cfg_shift;
      s1_sum   <= {psum_data[DATA_WIDTH-1], psum_data} + {cfg_bias[DATA_WIDTH-1], cfg_bias};
    end
  end

  // Round-shift, optional ReLU, then clamp to the signed output range.
  always_comb begin
    s2_ext     = {{(RS_WIDTH-DATA_WIDTH-1){s1_sum[DATA_WIDTH]}}, s1_sum};
    s2_rnd     = round_shift(s2_ext, 5'(s1_shift));
    s2_rect    = (s1_relu && (s2_rnd < 0)) ? '0 : s2_rnd;
    s2_clip_hi = (s2_rect > OUT_MAX);
    s2_clip_lo = (s2_rect < OUT_MIN);
    if (s2_clip_hi)      s2_sat = requant_t'(OUT_MAX);
    else if (s2_clip_lo) s2_sat = requant_t'(OUT_MIN);
    else                 s2_sat = s2_rect[OUT_W-1:0];
  end

  // S2 register holding the quantized lane value and its row-end flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_res   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      s2_res   <= s2_sat;
    end
  end

  // Merge the current result into the word being built and decide whether it ships now.
  always_comb begin
    word      = pack_data;
    word_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CNT_W'(i) == pack_cnt) word[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(s2_res);
      word_keep[i] = (CNT_W'(i) <= pack_cnt);
    end
    word_push = s2_valid && ((pack_cnt == CNT_W'(PACK-1)) || s2_last);
  end

  // Lane accumulator; cleared on each push so unwritten lanes of a short word read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_cnt  <= '0;
      pack_data <= '0;
    end else if (s2_valid) begin
      if (word_push) begin
        pack_cnt  <= '0;
        pack_data <= '0;
      end else begin
        pack_cnt  <= pack_cnt + CNT_W'(1);
        pack_data <= word;
      end
    end
  end

`ifdef PSUM_POST_SAT_CNT_EN
  // Count results clipped by saturation, holding at the top value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (s1_valid && (s2_clip_hi || s2_clip_lo) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

  psum_post_ofifo #(
    .WIDTH  (WORD_W),
    .KEEP_W (PACK),
    .DEPTH  (OFIFO_DEPTH)
  ) u_ofifo (
    .clk          (clk),
    .rst          (rst),
    .push         (word_push),
    .push_data    (word),
    .push_keep    (word_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .overflow_err (overflow_err)
  );

endmodule
